// File: rtl/sort4_sched_if.sv
// sort4_sched_if: load/drain handshake and status bundle for the 4-element sorter
interface sort4_sched_if;
  logic [3:0] i_data;
  logic       i_valid;
  logic       i_ready;
  logic [3:0] o_data;
  logic       o_valid;
  logic       o_ready;
  logic       o_last;
  logic       o_busy;
  logic [2:0] o_swaps;
  modport master (output i_data, i_valid, o_ready, input i_ready, o_data, o_valid, o_last, o_busy, o_swaps);
  modport slave  (input i_data, i_valid, o_ready, output i_ready, o_data, o_valid, o_last, o_busy, o_swaps);
endinterface

// File: rtl/sort4_sched.sv
// sort4_sched: loads four nibbles, bubble-sorts them with one shared comparator, drains them in order
module sort4_sched #(
  parameter bit DESCEND = 1'b0
) (
  input logic          clk,
  input logic          rst_n,
  sort4_sched_if.slave s
);
  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
  state_t     r_state, w_next;
  logic [3:0] r_r [4];
  logic [2:0] r_cnt, r_swaps;
  logic [1:0] w_j, w_j1;
  logic [3:0] w_a, w_b;
  logic [4:0] w_diff;
  logic       w_gt, w_in_fire, w_out_fire;
  // r_cnt is the load index k, the compare index, and the drain index m in turn
  assign w_j        = (r_cnt == 3'd1 || r_cnt == 3'd4) ? 2'd1 : (r_cnt == 3'd2) ? 2'd2 : 2'd0;
  assign w_j1       = w_j + 2'd1;
  assign w_a        = DESCEND ? r_r[w_j1] : r_r[w_j];
  assign w_b        = DESCEND ? r_r[w_j] : r_r[w_j1];
  // a > b exactly when b - a borrows
  assign w_diff     = {1'b0, w_b} - {1'b0, w_a};
  assign w_gt       = w_diff[4];
  assign w_in_fire  = s.i_valid && s.i_ready;
  assign w_out_fire = s.o_valid && s.o_ready;
  assign s.i_ready  = rst_n && (r_state == LOAD);
  assign s.o_valid  = (r_state == DRAIN);
  assign s.o_last   = (r_state == DRAIN) && (r_cnt[1:0] == 2'd3);
  assign s.o_data   = r_r[r_cnt[1:0]];
  assign s.o_busy   = (r_state != LOAD);
  assign s.o_swaps  = r_swaps;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == LOAD && w_in_fire && r_cnt[1:0] == 2'd3) ? SORT :
             (r_state == SORT && r_cnt == 3'd5) ? DRAIN :
             (r_state == DRAIN && w_out_fire && r_cnt[1:0] == 2'd3) ? LOAD : r_state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 3'd0;
      r_swaps <= 3'd0;
      r_r     <= '{default: 4'd0};
    end else begin
      case (r_state)
        LOAD: if (w_in_fire) begin
          r_r[r_cnt[1:0]] <= s.i_data;
          r_cnt           <= {1'b0, r_cnt[1:0] + 2'd1};
          if (r_cnt[1:0] == 2'd3) r_swaps <= 3'd0;
        end
        SORT: begin
          r_cnt <= (r_cnt == 3'd5) ? 3'd0 : r_cnt + 3'd1;
          if (w_gt) begin
            r_r[w_j]  <= r_r[w_j1];
            r_r[w_j1] <= r_r[w_j];
            r_swaps   <= r_swaps + 3'd1;
          end
        end
        DRAIN: if (w_out_fire) r_cnt <= {1'b0, r_cnt[1:0] + 2'd1};
        default: r_cnt <= 3'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_sort4_sched.sv
// tb_sort4_sched: scoreboard bench for ascending and descending sorter instances
module tb_sort4_sched;
  typedef struct {logic [3:0] d; logic l; logic [2:0] s;} exp_t;
  logic clk = 1'b0;
  logic rst_n, sel, vin, ordy;
  logic [3:0] din;
  int n_chk = 0, n_pass = 0;
  exp_t q[$];
  sort4_sched_if a_if ();
  sort4_sched_if d_if ();
  sort4_sched #(.DESCEND(1'b0)) u_asc (.clk(clk), .rst_n(rst_n), .s(a_if.slave));
  sort4_sched #(.DESCEND(1'b1)) u_dsc (.clk(clk), .rst_n(rst_n), .s(d_if.slave));
  always #5 clk = ~clk;
  assign a_if.i_data = din;
  assign a_if.i_valid = vin;
  assign a_if.o_ready = ordy;
  assign d_if.i_data = din;
  assign d_if.i_valid = vin;
  assign d_if.o_ready = ordy;
  wire       w_ir = sel ? d_if.i_ready : a_if.i_ready;
  wire       w_ov = sel ? d_if.o_valid : a_if.o_valid;
  wire       w_ol = sel ? d_if.o_last : a_if.o_last;
  wire       w_bz = sel ? d_if.o_busy : a_if.o_busy;
  wire [3:0] w_od = sel ? d_if.o_data : a_if.o_data;
  wire [2:0] w_sw = sel ? d_if.o_swaps : a_if.o_swaps;
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask
  always @(negedge clk) begin
    if (rst_n && w_ov && ordy) begin
      if (q.size() == 0) check("unexpected_output", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("o_data", int'(w_od), int'(e.d));
        check("o_last", int'(w_ol), int'(e.l));
        check("swaps", int'(w_sw), int'(e.s));
      end
    end
  end
  task automatic send(input logic [3:0] v);
    int t = 0;
    @(negedge clk);
    din = v;
    vin = 1'b1;
    while (!w_ir && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1 vin = 1'b0;
  endtask
  task automatic run_set(input logic [3:0] v0, v1, v2, v3, input bit push);
    logic [3:0] v[4];
    int srt[$];
    int inv = 0;
    exp_t e;
    v = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      srt.push_back(int'(v[i]));
      for (int j = i + 1; j < 4; j++) if (sel ? v[j] > v[i] : v[i] > v[j]) inv++;
    end
    if (sel) srt.rsort(); else srt.sort();
    if (push) for (int i = 0; i < 4; i++) begin
      e.d = 4'(srt[i]);
      e.l = (i == 3);
      e.s = 3'(inv);
      q.push_back(e);
    end
    for (int i = 0; i < 4; i++) send(v[i]);
  endtask
  task automatic wait_drain;
    int t = 0;
    while (q.size() != 0 && t < 200) begin
      @(negedge clk);
      #1 t++;
    end
    check("drain_done", q.size(), 0);
    @(posedge clk);
    #1 check("ready_after_last", int'(w_ir), 1);
    check("idle_after_last", int'(w_bz), 0);
  endtask
  initial begin
    int t, e;
    rst_n = 1'b0; sel = 1'b0; vin = 1'b0; din = 4'd0; ordy = 1'b1;
    #2 check("rst_busy", int'(w_bz), 0);
    check("rst_i_ready", int'(w_ir), 0);
    check("rst_o_valid", int'(w_ov), 0);
    check("rst_o_data", int'(w_od), 0);
    check("rst_swaps", int'(w_sw), 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_after_rst", int'(w_ir), 1);
    run_set(4'd3, 4'd1, 4'd2, 4'd0, 1'b1);
    wait_drain();
    run_set(4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
    check("sort_i_ready", int'(w_ir), 0);
    check("sort_busy", int'(w_bz), 1);
    e = 0;
    while (!w_ov && e < 20) begin
      @(posedge clk);
      #1 e++;
    end
    check("latency", e, 6);
    wait_drain();
    run_set(4'd15, 4'd0, 4'd15, 4'd0, 1'b1);
    wait_drain();
    ordy = 1'b0;
    run_set(4'd5, 4'd12, 4'd2, 4'd9, 1'b1);
    t = 0;
    while (!w_ov && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    check("bp_valid", int'(w_ov), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check("bp_hold_data", int'(w_od), int'(q[0].d));
      check("bp_hold_last", int'(w_ol), 0);
      check("bp_hold_swaps", int'(w_sw), int'(q[0].s));
    end
    @(posedge clk);
    #1 ordy = 1'b1;
    wait_drain();
    run_set(4'd3, 4'd1, 4'd2, 4'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midsort_rst_busy", int'(w_bz), 0);
    check("midsort_rst_ready", int'(w_ir), 0);
    check("midsort_rst_valid", int'(w_ov), 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_set(4'd9, 4'd8, 4'd7, 4'd6, 1'b1);
    wait_drain();
    sel = 1'b1;
    run_set(4'd3, 4'd1, 4'd2, 4'd0, 1'b1);
    wait_drain();
    sel = 1'b0;
    for (int n = 0; n < 4; n++) begin
      run_set(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
      wait_drain();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sort4_sched.md
SORT4_SCHED -- requirements
Module: sort4_sched

Interface
REQ-001 Parameter: DESCEND, default 0, output order select (0 = ascending, 1 = descending).
REQ-002 CLK  input  1  single clock; all state SHALL update on rising edge.
REQ-003 RESETN  input  1  reset, asynchronous, active-low.
REQ-004 I  input  4  unsigned input nibble.
REQ-005 I_VALID  input  1  input nibble valid.
REQ-006 I_READY  output  1  block accepts input this cycle.
REQ-007 O  output  4  unsigned sorted output nibble.
REQ-008 O_VALID  output  1  O holds a valid element.
REQ-009 O_READY  input  1  downstream accepts O this cycle.
REQ-010 O_LAST  output  1  O is the 4th (final) element of the set.
REQ-011 BUSY  output  1  high in SORT or DRAIN.
REQ-012 SWAPS  output  3  number of swaps performed in the last sort; valid while O_VALID.

Function
REQ-013 Block SHALL contain four 4-bit element registers R0..R3 and exactly one 4-bit unsigned greater-than comparator (subtract-and-carry form); all ordering decisions SHALL use only that comparator, one compare per cycle.
REQ-014 FSM states SHALL be LOAD, SORT, DRAIN; no others.
REQ-015 LOAD: I_READY=1; each cycle with I_VALID&&I_READY SHALL write I into R[k] (k = load count 0..3, in arrival order) and increment k.
REQ-016 The edge accepting the 4th element SHALL move the FSM to SORT, clear SWAPS and reset the compare index.
REQ-017 SORT SHALL run exactly 6 cycles, comparing pairs in fixed order (0,1),(1,2),(2,3),(0,1),(1,2),(0,1); no early exit.
REQ-018 Ascending: comparator I0=R[j], I1=R[j+1]; swap R[j],R[j+1] on the edge when GT=1. Descending: operands exchanged, swap when R[j+1] >u R[j].
REQ-019 Equal elements SHALL never swap (stable sort).
REQ-020 Each swap SHALL increment SWAPS (max 6, no wrap possible).
REQ-021 The 6th compare edge SHALL move the FSM to DRAIN with output index m=0; O_VALID SHALL assert 6 clock edges after the edge accepting the 4th input.
REQ-022 DRAIN: O_VALID=1, O=R[m], O_LAST=(m==3); m SHALL advance only on O_VALID&&O_READY.
REQ-023 O, O_LAST, SWAPS SHALL remain stable while O_VALID=1 and O_READY=0, for any number of cycles.
REQ-024 Handshake on m==3 SHALL return FSM to LOAD with k=0; I_READY SHALL be 1 in the following cycle.
REQ-025 I_READY=0 in SORT and DRAIN; I and I_VALID SHALL be ignored there.
REQ-026 O_VALID=0 and O_LAST=0 in LOAD and SORT; O value then don't-care but SHALL not be X after reset.
REQ-027 BUSY SHALL equal (state != LOAD).
REQ-028 Partial loads (k<4) SHALL be held indefinitely; no timeout.

Reset
REQ-029 RESETN=0 SHALL immediately (no clock needed) force LOAD, k=0, m=0, R0..R3=0, SWAPS=0, O_VALID=0, O_LAST=0, BUSY=0, I_READY=0.
REQ-030 I_READY SHALL be 0 while RESETN=0 and 1 from the first cycle after release.
REQ-031 Reset asserted mid-LOAD, SORT or DRAIN SHALL discard all partial data; next set SHALL sort correctly.

Verification
REQ-032 DESCEND=0, load 3,1,2,0 -> O sequence 0,1,2,3, O_LAST only on 3, SWAPS=5.
REQ-033 DESCEND=0, load 1,2,3,4 with O_READY=1 -> O_VALID rises exactly 6 edges after 4th accept, O 1,2,3,4, SWAPS=0, I_READY=1 the cycle after the 4th output.
REQ-034 DESCEND=0, load 15,0,15,0 -> O 0,0,15,15, SWAPS=3 (stability of equals).
REQ-035 Backpressure: O_READY=0 for 5 cycles at start of DRAIN, then 1 -> O=first element held 5 cycles, all 4 elements delivered once, none lost or repeated.
REQ-036 Assert RESETN=0 on 3rd SORT cycle, release, load 9,8,7,6 -> BUSY=0 immediately on reset, then O 6,7,8,9, SWAPS=6.
REQ-037 DESCEND=1, load 3,1,2,0 -> O 3,2,1,0, SWAPS=1.
